// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong bank read controller.
package pingpong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2
  } pp_state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic pp_state_e rd_state_for(input logic bank);
    return (bank == BANK_A) ? ST_RD_A : ST_RD_B;
  endfunction

endpackage

// File: rtl/pp_skid_buf.sv
// Two-entry output FIFO holding {last, data} words between the bank read port
// and the ready/valid stream; output data reads as zero while empty.
module pp_skid_buf
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt_q;
  logic             pop_ok;

  assign out_valid = (cnt_q != 2'd0);
  assign pop_ok    = pop & out_valid;
  assign count     = cnt_q;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + 2'(push) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/pingpong_rd_ctrl.sv
// Reader side of a ping-pong buffer: drains full banks A/B alternately into a
// ready/valid stream, releasing each bank with a one-cycle bank_done pulse.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for bank_full on the bank named by the pointer
//   ST_RD_A | strobing bank A addresses 0..DEPTH-1
//   ST_RD_B | strobing bank B addresses 0..DEPTH-1
module pingpong_rd_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic [1:0]           bank_full,
  output logic [1:0]           bank_done,
  output logic                 rd_en_a,
  output logic                 rd_en_b,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [DATA_SIZE-1:0] dout_a,
  input  logic [DATA_SIZE-1:0] dout_b,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
);

  pp_state_e            state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 inflight_bank_q;
  logic [1:0]           bank_done_q;
  logic                 strobe;
  logic                 last_rd;
  logic                 pop;
  logic [1:0]           fifo_cnt;
  logic [2:0]           slots_used;
  logic [DATA_SIZE:0]   push_word;
  logic [DATA_SIZE:0]   out_word;

  assign pop = m_valid & m_ready;
  // A word leaving this cycle frees its slot, which keeps one word per cycle.
  assign slots_used = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    strobe  = 1'b0;
    last_rd = 1'b0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_full[ptr_q]) state_d = rd_state_for(ptr_q);
      end
      ST_RD_A, ST_RD_B: begin
        strobe  = (slots_used < 3'd2);
        rd_en_a = strobe && (state_q == ST_RD_A);
        rd_en_b = strobe && (state_q == ST_RD_B);
        last_rd = strobe && (addr_q == '1);
        if (last_rd) begin
          ptr_d   = ~ptr_q;
          state_d = bank_full[~ptr_q] ? rd_state_for(~ptr_q) : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= BANK_A;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_bank_q <= BANK_A;
      bank_done_q     <= 2'b00;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      if (strobe) addr_q <= addr_q + 1'b1;
      inflight_q      <= strobe;
      inflight_last_q <= last_rd;
      inflight_bank_q <= (state_q == ST_RD_B) ? BANK_B : BANK_A;
      bank_done_q     <= last_rd ? ((state_q == ST_RD_A) ? 2'b01 : 2'b10) : 2'b00;
    end
  end

  assign push_word = {inflight_last_q, (inflight_bank_q == BANK_B) ? dout_b : dout_a};

  pp_skid_buf #(
    .WIDTH(DATA_SIZE + 1)
  ) u_obuf (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(push_word),
    .pop      (m_ready),
    .out_data (out_word),
    .out_valid(m_valid),
    .count    (fifo_cnt)
  );

  assign m_data    = out_word[DATA_SIZE-1:0];
  assign m_last    = out_word[DATA_SIZE];
  assign rd_addr   = addr_q;
  assign bank_done = bank_done_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// Directed bench for pingpong_rd_ctrl with 4-word banks; bank A word i reads
// as 16'hA000+i and bank B word i as 16'hB000+i.
module tb_pingpong_rd_ctrl;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bank_full = 2'b00;
  logic [1:0]  bank_done;
  logic        rd_en_a, rd_en_b;
  logic [1:0]  rd_addr;
  logic [15:0] dout_a = 16'h0;
  logic [15:0] dout_b = 16'h0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  pingpong_rd_ctrl #(.DATA_SIZE(16), .ADDR_SIZE(2)) dut (
    .rd_clk(rd_clk), .rst(rst), .bank_full(bank_full), .bank_done(bank_done),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr(rd_addr),
    .dout_a(dout_a), .dout_b(dout_b), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (rd_en_a) dout_a <= 16'hA000 + {14'd0, rd_addr};
    if (rd_en_b) dout_b <= 16'hB000 + {14'd0, rd_addr};
  end

  int          strobe_cyc[$];
  logic [1:0]  strobe_addr[$];
  logic        strobe_bank[$];
  logic [15:0] word_data[$];
  logic        word_last[$];
  int          done_cyc[$];
  logic [1:0]  done_val[$];
  int          first_valid_cyc = -1;
  int          outstanding = 0;
  int          max_out = 0;
  int          both_err = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic        prev_last = 1'b0;

  // Sampled mid-cycle, so values seen here are the ones the next edge acts on.
  always @(negedge rd_clk) begin
    if (rd_en_a && rd_en_b) both_err++;
    if (rd_en_a || rd_en_b) begin
      strobe_cyc.push_back(cyc);
      strobe_addr.push_back(rd_addr);
      strobe_bank.push_back(rd_en_b);
      outstanding++;
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && !rst && (!m_valid || m_data !== prev_data || m_last !== prev_last))
      stall_err++;
    if (m_valid && m_ready) begin
      word_data.push_back(m_data);
      word_last.push_back(m_last);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (bank_done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_val.push_back(bank_done);
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    strobe_cyc.delete(); strobe_addr.delete(); strobe_bank.delete();
    word_data.delete(); word_last.delete();
    done_cyc.delete(); done_val.delete();
    first_valid_cyc = -1;
    outstanding = 0;
    max_out = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bank_full = 2'b00;
    tick(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd_en"}, {62'd0, rd_en_a, rd_en_b}, 64'd0);
    check({tag, "_rd_addr"}, {62'd0, rd_addr}, 64'd0);
    check({tag, "_bank_done"}, {62'd0, bank_done}, 64'd0);
    check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    check({tag, "_m_last"}, {63'd0, m_last}, 64'd0);
    check({tag, "_m_data"}, {48'd0, m_data}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] pack_words(input int base);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (base + i < word_data.size()) r[(3-i)*16 +: 16] = word_data[base+i];
    return r;
  endfunction

  function automatic logic [63:0] pack_addrs(input int base);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (base + i < strobe_addr.size()) r[(3-i)*4 +: 4] = {2'b00, strobe_addr[base+i]};
    return r;
  endfunction

  function automatic logic [63:0] bank_mask();
    logic [63:0] r = '0;
    for (int i = 0; i < strobe_bank.size() && i < 64; i++) r[i] = strobe_bank[i];
    return r;
  endfunction

  function automatic logic [63:0] last_mask();
    logic [63:0] r = '0;
    for (int i = 0; i < word_last.size() && i < 64; i++) r[i] = word_last[i];
    return r;
  endfunction

  function automatic logic [63:0] done_at(input int i);
    return (i < done_val.size()) ? {62'd0, done_val[i]} : 64'hFFFF;
  endfunction

  function automatic int scyc(input int i);
    return (i < strobe_cyc.size()) ? strobe_cyc[i] : -100;
  endfunction

  function automatic int dcyc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -100;
  endfunction

  initial begin
    // Reset values while rst is held
    tick(3);
    check_reset_outs("rst");
    rst = 1'b0;
    clear_logs();

    // Single bank A at full throughput
    bank_full = 2'b01;
    m_ready = 1'b1;
    tick(16);
    check("t1_n_strobes", strobe_cyc.size(), 4);
    check("t1_addrs", pack_addrs(0), 64'h0123);
    check("t1_consecutive", scyc(3) - scyc(0), 3);
    check("t1_banks", bank_mask(), 64'h0);
    check("t1_words", pack_words(0), 64'hA000_A001_A002_A003);
    check("t1_n_words", word_data.size(), 4);
    check("t1_last", last_mask(), 64'h8);
    check("t1_latency", first_valid_cyc - scyc(0), 2);
    check("t1_n_done", done_cyc.size(), 1);
    check("t1_done_val", done_at(0), 64'h1);
    check("t1_done_cyc", dcyc(0) - scyc(3), 1);
    check("t1_idle_busy", {63'd0, busy}, 64'd0);

    // Both banks full: A then B without a bubble
    do_reset();
    bank_full = 2'b11;
    tick(6);
    bank_full = 2'b00;
    tick(14);
    check("t2_n_strobes", strobe_cyc.size(), 8);
    check("t2_no_bubble", scyc(7) - scyc(0), 7);
    check("t2_banks", bank_mask(), 64'hF0);
    check("t2_addrs_a", pack_addrs(0), 64'h0123);
    check("t2_addrs_b", pack_addrs(4), 64'h0123);
    check("t2_words_a", pack_words(0), 64'hA000_A001_A002_A003);
    check("t2_words_b", pack_words(4), 64'hB000_B001_B002_B003);
    check("t2_last", last_mask(), 64'h88);
    check("t2_n_done", done_cyc.size(), 2);
    check("t2_done0", done_at(0), 64'h1);
    check("t2_done1", done_at(1), 64'h2);
    check("t2_done_gap", dcyc(1) - dcyc(0), 4);

    // Only B full after reset: pointer names A, so nothing happens
    do_reset();
    bank_full = 2'b10;
    tick(8);
    check("t3_no_strobe", strobe_cyc.size(), 0);
    bank_full = 2'b11;
    tick(6);
    bank_full = 2'b00;
    tick(14);
    check("t3_first_bank", bank_mask() & 64'h1, 64'h0);
    check("t3_first_addr", pack_addrs(0), 64'h0123);
    check("t3_n_strobes", strobe_cyc.size(), 8);

    // Back-pressure: toggling ready, then a 5-cycle stall
    do_reset();
    bank_full = 2'b01;
    for (int i = 0; i < 8; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b0;
    tick(5);
    m_ready = 1'b1;
    tick(10);
    check("t4_n_words", word_data.size(), 4);
    check("t4_words", pack_words(0), 64'hA000_A001_A002_A003);
    check("t4_last", last_mask(), 64'h8);
    check("t4_max_outstanding", max_out, 2);
    check("t4_n_strobes", strobe_cyc.size(), 4);
    check("t4_n_done", done_cyc.size(), 1);

    // Reset mid-bank, then restart on bank A
    do_reset();
    bank_full = 2'b01;
    m_ready = 1'b1;
    begin
      int budget = 20;
      while (!(m_valid && word_data.size() == 1) && budget > 0) begin
        tick();
        budget--;
      end
      check("t5_wait_2nd_word", budget > 0, 1);
    end
    rst = 1'b1;
    tick();
    check_reset_outs("t5_rst");
    check("t5_words_pre", pack_words(0), 64'hA000_A001_0000_0000);
    bank_full = 2'b00;
    rst = 1'b0;
    tick(4);
    check("t5_no_done", done_cyc.size(), 0);
    clear_logs();
    bank_full = 2'b01;
    tick(14);
    check("t5_restart_addrs", pack_addrs(0), 64'h0123);
    check("t5_restart_bank", bank_mask(), 64'h0);
    check("t5_restart_words", pack_words(0), 64'hA000_A001_A002_A003);
    check("t5_restart_done", done_at(0), 64'h1);

    // bank_full[0] falls while A is being read
    do_reset();
    bank_full = 2'b01;
    tick(2);
    bank_full = 2'b00;
    tick(14);
    check("t6_n_strobes", strobe_cyc.size(), 4);
    check("t6_words", pack_words(0), 64'hA000_A001_A002_A003);
    check("t6_n_done", done_cyc.size(), 1);
    check("t6_done_val", done_at(0), 64'h1);

    check("never_both_strobes", both_err, 0);
    check("stall_hold_stable", stall_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
